// File: rtl/jtcop_dtack_if.sv
// Bus signals between the 68000 side and the DTACK responder.
// Strobes, chip selects and ready flags flow in; DTACKn and status flow out.
interface jtcop_dtack_if;
    logic       cpu_cen;
    logic       ASn;
    logic       UDSn;
    logic       LDSn;
    logic       rom_cs;
    logic       rom_ok;
    logic       ram_cs;
    logic       ram_ok;
    logic       disp_cs;
    logic       DTACKn;
    logic       bus_err;
    logic [7:0] wait_cnt;

    modport master (
        output cpu_cen, ASn, UDSn, LDSn, rom_cs, rom_ok, ram_cs, ram_ok, disp_cs,
        input  DTACKn, bus_err, wait_cnt
    );

    modport slave (
        input  cpu_cen, ASn, UDSn, LDSn, rom_cs, rom_ok, ram_cs, ram_ok, disp_cs,
        output DTACKn, bus_err, wait_cnt
    );
endinterface

// File: rtl/jtcop_dtack.sv
// DTACKn responder for the main 68000: fixed display wait states, ROM/RAM ready
// hold-off and a timeout that forces an acknowledge on a hung slot.
module jtcop_dtack #(
    parameter int unsigned DISP_WAIT = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         rst,
    jtcop_dtack_if.slave bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    localparam logic [3:0] DispLoad = 4'(DISP_WAIT);
    localparam logic [7:0] TmoLimit = 8'(TIMEOUT);

    logic [1:0] state_q, state_d;
    logic [3:0] dly_q, dly_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] tmo_inc;
    logic       arm_q, arm_d;
    logic       dtack_q, dtack_d;
    logic       berr_q, berr_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       cycle_start;
    logic       ready;

    assign cycle_start = !bus.ASn && (!bus.UDSn || !bus.LDSn);
    assign tmo_inc     = (tmo_q == 8'hff) ? tmo_q : tmo_q + 8'd1;

    // arm masks ready flags left over from the previous cycle
    assign ready = arm_q && (dly_q == 4'd0) &&
                   (!bus.rom_cs || bus.rom_ok) && (!bus.ram_cs || bus.ram_ok);

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        tmo_d   = tmo_q;
        arm_d   = arm_q;
        dtack_d = dtack_q;
        berr_d  = berr_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            StIdle: begin
                if (cycle_start) begin
                    state_d = StWait;
                    dly_d   = bus.disp_cs ? DispLoad : 4'd0;
                    tmo_d   = 8'd0;
                    arm_d   = 1'b0;
                end
            end
            StWait: begin
                arm_d = 1'b1;
                if (bus.ASn) begin
                    state_d = StIdle;
                end else if (bus.cpu_cen) begin
                    if (dly_q != 4'd0) dly_d = dly_q - 4'd1;
                    // tmo counts only armed ticks, so wait_cnt excludes the arming clk
                    if (arm_q) tmo_d = tmo_inc;
                    if (ready) begin
                        state_d = StAck;
                        dtack_d = 1'b0;
                        wcnt_d  = tmo_inc;
                    end else if (arm_q && (tmo_inc == TmoLimit)) begin
                        state_d = StAck;
                        dtack_d = 1'b0;
                        berr_d  = 1'b1;
                        wcnt_d  = tmo_inc;
                    end
                end
            end
            StAck: begin
                if (bus.ASn) begin
                    state_d = StIdle;
                    dtack_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                dtack_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dly_q   <= 4'd0;
            tmo_q   <= 8'd0;
            arm_q   <= 1'b0;
            dtack_q <= 1'b1;
            berr_q  <= 1'b0;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            tmo_q   <= tmo_d;
            arm_q   <= arm_d;
            dtack_q <= dtack_d;
            berr_q  <= berr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.DTACKn   = dtack_q;
    assign bus.bus_err  = berr_q;
    assign bus.wait_cnt = wcnt_q;

endmodule
